// File: rtl/usb_rx_pkt.sv
// rtl/usb_rx_pkt.sv - USB full-speed packet receiver: clock recovery, NRZI/unstuff, PID/CRC checks, payload push
//
// Ports:
//   clk, n_rst            system clock, asynchronous active-low reset
//   dp_in, dm_in          raw USB line pair (asynchronous to clk)
//   buffer_occupancy      current fill level of the downstream RX FIFO
//   flush                 one-cycle pulse when a DATA PID is accepted
//   rx_store_packet_data  one-cycle push strobe, rx_packet_data valid with it
//   rx_packet_data        payload byte (CRC bytes are never pushed)
//   rx_packet             last accepted PID code (0 none .. 7 STALL)
//   rx_token_addr/endp    token fields, updated when a token completes
//   rx_data_ready         one-cycle pulse for an error-free packet
//   rx_transfer_active    high from SYNC detect to end of packet or error
//   rx_error              sticky error flag, cleared by the next SYNC
module usb_rx_pkt #(
    parameter int PHASE_W      = 16,
    parameter int PHASE_INC    = 7864,
    parameter int BUFFER_DEPTH = 64,
    parameter int OCC_W        = $clog2(BUFFER_DEPTH + 1),
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             dp_in,
    input  logic             dm_in,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             flush,
    output logic             rx_store_packet_data,
    output logic [7:0]       rx_packet_data,
    output logic [2:0]       rx_packet,
    output logic [6:0]       rx_token_addr,
    output logic [3:0]       rx_token_endp,
    output logic             rx_data_ready,
    output logic             rx_transfer_active,
    output logic             rx_error
);

    localparam int PC_W = $clog2(MAX_PAYLOAD + 1);
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic [PHASE_W-1:0] INC  = PHASE_W'(PHASE_INC);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_BODY, S_EOP, S_ERR_WAIT} state_t;
    typedef enum logic [1:0] {K_HS, K_TOK, K_DATA} kind_t;

    // Synchronisers reset to J so leaving reset does not look like a line change.
    logic [1:0] dp_sync, dm_sync;
    logic [1:0] line, line_q;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   sum;
    logic change, strobe;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
            line_q  <= LS_J;
            acc     <= HALF;
        end else begin
            dp_sync <= {dp_sync[0], dp_in};
            dm_sync <= {dm_sync[0], dm_in};
            line_q  <= line;
            acc     <= change ? HALF : sum[PHASE_W-1:0];
        end
    end

    assign line   = {dp_sync[1], dm_sync[1]};
    assign change = (line != line_q);
    assign sum    = {1'b0, acc} + {1'b0, INC};
    // A line transition re-centres the accumulator, so the next carry lands mid-bit.
    assign strobe = !change && sum[PHASE_W];

    state_t state, state_next;
    kind_t  kind, kind_next;
    logic [1:0]  prev_ln, prev_next;
    logic [2:0]  ones, ones_next;
    logic [7:0]  sync_sr, sync_next;
    logic [7:0]  sh, sh_next;
    logic [2:0]  bcnt, bcnt_next;
    logic [4:0]  crc5, crc5_next;
    logic [15:0] crc16, crc16_next;
    logic [7:0]  d0, d0_next, d1, d1_next;
    logic [1:0]  nbytes, nbytes_next;
    logic [PC_W-1:0] push_cnt, push_next;
    logic [1:0]  se0_cnt, se0_next;
    logic [2:0]  j_cnt, j_next;
    logic        seen_se0, seen_next;
    logic        flush_next, store_next, ready_next, active_next, error_next;
    logic [7:0]  data_next;
    logic [2:0]  packet_next;
    logic [6:0]  addr_next;
    logic [3:0]  endp_next;
    logic        fail, bit_val, is_jk, pkt_ok;
    logic [7:0]  byte_val;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= S_IDLE;
            kind                 <= K_HS;
            prev_ln              <= LS_J;
            ones                 <= 3'd0;
            sync_sr              <= 8'hFF;
            sh                   <= 8'h00;
            bcnt                 <= 3'd0;
            crc5                 <= 5'h1F;
            crc16                <= 16'hFFFF;
            d0                   <= 8'h00;
            d1                   <= 8'h00;
            nbytes               <= 2'd0;
            push_cnt             <= '0;
            se0_cnt              <= 2'd0;
            j_cnt                <= 3'd0;
            seen_se0             <= 1'b0;
            flush                <= 1'b0;
            rx_store_packet_data <= 1'b0;
            rx_packet_data       <= 8'h00;
            rx_packet            <= 3'd0;
            rx_token_addr        <= 7'd0;
            rx_token_endp        <= 4'd0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
        end else begin
            state                <= state_next;
            kind                 <= kind_next;
            prev_ln              <= prev_next;
            ones                 <= ones_next;
            sync_sr              <= sync_next;
            sh                   <= sh_next;
            bcnt                 <= bcnt_next;
            crc5                 <= crc5_next;
            crc16                <= crc16_next;
            d0                   <= d0_next;
            d1                   <= d1_next;
            nbytes               <= nbytes_next;
            push_cnt             <= push_next;
            se0_cnt              <= se0_next;
            j_cnt                <= j_next;
            seen_se0             <= seen_next;
            flush                <= flush_next;
            rx_store_packet_data <= store_next;
            rx_packet_data       <= data_next;
            rx_packet            <= packet_next;
            rx_token_addr        <= addr_next;
            rx_token_endp        <= endp_next;
            rx_data_ready        <= ready_next;
            rx_transfer_active   <= active_next;
            rx_error             <= error_next;
        end
    end

    always_comb begin
        state_next  = state;
        kind_next   = kind;
        prev_next   = prev_ln;
        ones_next   = ones;
        sync_next   = sync_sr;
        sh_next     = sh;
        bcnt_next   = bcnt;
        crc5_next   = crc5;
        crc16_next  = crc16;
        d0_next     = d0;
        d1_next     = d1;
        nbytes_next = nbytes;
        push_next   = push_cnt;
        se0_next    = se0_cnt;
        j_next      = j_cnt;
        seen_next   = seen_se0;
        flush_next  = 1'b0;
        store_next  = 1'b0;
        ready_next  = 1'b0;
        data_next   = rx_packet_data;
        packet_next = rx_packet;
        addr_next   = rx_token_addr;
        endp_next   = rx_token_endp;
        active_next = rx_transfer_active;
        error_next  = rx_error;
        fail        = 1'b0;
        pkt_ok      = 1'b0;
        is_jk       = (line == LS_J) || (line == LS_K);
        bit_val     = (line == prev_ln);
        byte_val    = {bit_val, sh[7:1]};

        if (strobe) begin
            if (is_jk) prev_next = line;
            unique case (state)
                S_IDLE: begin
                    if (is_jk) begin
                        sync_next = {bit_val, sync_sr[7:1]};
                        // KJKJKJKK arrives LSB-first as 0x80
                        if ({bit_val, sync_sr[7:1]} == 8'h80) begin
                            state_next  = S_PID;
                            active_next = 1'b1;
                            error_next  = 1'b0;
                            ones_next   = 3'd1;   // last SYNC bit counts toward stuffing
                            bcnt_next   = 3'd0;
                            crc5_next   = 5'h1F;
                            crc16_next  = 16'hFFFF;
                            nbytes_next = 2'd0;
                            push_next   = '0;
                        end
                    end
                end
                S_PID, S_BODY: begin
                    if (line == LS_SE1) begin
                        fail = 1'b1;
                    end else if (line == LS_SE0) begin
                        if (state == S_PID) fail = 1'b1;
                        else begin
                            state_next = S_EOP;
                            se0_next   = 2'd1;
                        end
                    end else if (ones == 3'd6) begin
                        if (bit_val) fail = 1'b1;
                        else ones_next = 3'd0;
                    end else begin
                        ones_next = bit_val ? ones + 3'd1 : 3'd0;
                        sh_next   = byte_val;
                        bcnt_next = bcnt + 3'd1;
                        if (state == S_PID) begin
                            if (bcnt == 3'd7) begin
                                state_next = S_BODY;
                                if (byte_val[7:4] != ~byte_val[3:0]) fail = 1'b1;
                                else begin
                                    unique case (byte_val[3:0])
                                        4'h1: begin packet_next = 3'd1; kind_next = K_TOK; end
                                        4'h9: begin packet_next = 3'd2; kind_next = K_TOK; end
                                        4'h3: begin packet_next = 3'd3; kind_next = K_DATA; flush_next = 1'b1; end
                                        4'hB: begin packet_next = 3'd4; kind_next = K_DATA; flush_next = 1'b1; end
                                        4'h2: begin packet_next = 3'd5; kind_next = K_HS; end
                                        4'hA: begin packet_next = 3'd6; kind_next = K_HS; end
                                        4'hE: begin packet_next = 3'd7; kind_next = K_HS; end
                                        default: fail = 1'b1;
                                    endcase
                                end
                            end
                        end else if (kind == K_HS) begin
                            fail = 1'b1;
                        end else begin
                            crc5_next  = {crc5[3:0], 1'b0} ^ ((crc5[4] ^ bit_val) ? 5'h05 : 5'h00);
                            crc16_next = {crc16[14:0], 1'b0} ^ ((crc16[15] ^ bit_val) ? 16'h8005 : 16'h0000);
                            if (bcnt == 3'd7) begin
                                if (kind == K_TOK) begin
                                    if (nbytes == 2'd2) fail = 1'b1;
                                end else if (nbytes == 2'd2) begin
                                    // Oldest byte leaves the delay line; the final two stay behind as CRC.
                                    if (buffer_occupancy >= OCC_W'(BUFFER_DEPTH) ||
                                        push_cnt == PC_W'(MAX_PAYLOAD)) begin
                                        fail = 1'b1;
                                    end else begin
                                        store_next = 1'b1;
                                        data_next  = d1;
                                        push_next  = push_cnt + PC_W'(1);
                                    end
                                end
                                d1_next = d0;
                                d0_next = byte_val;
                                if (nbytes != 2'd2) nbytes_next = nbytes + 2'd1;
                            end
                        end
                    end
                end
                S_EOP: begin
                    if (line == LS_SE0) begin
                        if (se0_cnt == 2'd2) fail = 1'b1;
                        else se0_next = se0_cnt + 2'd1;
                    end else if (line == LS_J) begin
                        unique case (kind)
                            K_HS:    pkt_ok = (nbytes == 2'd0) && (bcnt == 3'd0);
                            K_TOK:   pkt_ok = (nbytes == 2'd2) && (bcnt == 3'd0) && (crc5 == 5'b01100);
                            default: pkt_ok = (nbytes == 2'd2) && (bcnt == 3'd0) && (crc16 == 16'h800D);
                        endcase
                        if (pkt_ok) begin
                            ready_next  = 1'b1;
                            active_next = 1'b0;
                            state_next  = S_IDLE;
                            sync_next   = 8'hFF;
                            if (kind == K_TOK) begin
                                addr_next = d1[6:0];
                                endp_next = {d0[2:0], d1[7]};
                            end
                        end else begin
                            fail = 1'b1;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
                S_ERR_WAIT: begin
                    if (line == LS_SE0) begin
                        seen_next = 1'b1;
                        j_next    = 3'd0;
                    end else if (line == LS_J) begin
                        if (seen_se0 || j_cnt == 3'd7) begin
                            state_next = S_IDLE;
                            sync_next  = 8'hFF;
                        end else begin
                            j_next = j_cnt + 3'd1;
                        end
                    end else begin
                        seen_next = 1'b0;
                        j_next    = 3'd0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        if (fail) begin
            state_next  = S_ERR_WAIT;
            error_next  = 1'b1;
            active_next = 1'b0;
            store_next  = 1'b0;
            j_next      = 3'd0;
            seen_next   = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt.sv
// tb/tb_usb_rx_pkt.sv - directed self-checking bench for usb_rx_pkt
module tb_usb_rx_pkt;

    localparam int BIT_T = 83;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dp_in, dm_in;
    logic [6:0] buffer_occupancy;
    logic       flush, rx_store_packet_data, rx_data_ready, rx_transfer_active, rx_error;
    logic [7:0] rx_packet_data;
    logic [2:0] rx_packet;
    logic [6:0] rx_token_addr;
    logic [3:0] rx_token_endp;

    always #5 clk = ~clk;

    usb_rx_pkt dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .dp_in                (dp_in),
        .dm_in                (dm_in),
        .buffer_occupancy     (buffer_occupancy),
        .flush                (flush),
        .rx_store_packet_data (rx_store_packet_data),
        .rx_packet_data       (rx_packet_data),
        .rx_packet            (rx_packet),
        .rx_token_addr        (rx_token_addr),
        .rx_token_endp        (rx_token_endp),
        .rx_data_ready        (rx_data_ready),
        .rx_transfer_active   (rx_transfer_active),
        .rx_error             (rx_error)
    );

    int total = 0;
    int bad = 0;
    int n_ready = 0;
    int n_flush = 0;
    logic [7:0] store_q[$];
    logic [7:0] pl[$];
    logic lvl;
    int   ones;
    logic bad_stuff = 1'b0;
    int   r0, f0, s0;

    always @(negedge clk) begin
        if (rx_data_ready) n_ready <= n_ready + 1;
        if (flush) n_flush <= n_flush + 1;
        if (rx_store_packet_data) store_q.push_back(rx_packet_data);
    end

    task automatic drive(input logic p, input logic m);
        dp_in = p;
        dm_in = m;
        #(BIT_T);
    endtask

    task automatic send_bit(input logic b);
        if (!b) lvl = ~lvl;
        drive(lvl, ~lvl);
        if (b) begin
            ones++;
            if (ones == 6) begin
                if (bad_stuff) begin
                    drive(lvl, ~lvl);
                    bad_stuff = 1'b0;
                end else begin
                    lvl = ~lvl;
                    drive(lvl, ~lvl);
                end
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic send_sync();
        lvl  = 1'b1;
        ones = 0;
        send_byte(8'h80);
    endtask

    task automatic send_eop();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        idle(6);
    endtask

    task automatic send_data(input logic [7:0] pid, input logic corrupt);
        logic [15:0] crc;
        logic b;
        send_sync();
        send_byte(pid);
        crc = 16'hFFFF;
        for (int i = 0; i < pl.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                b = pl[i][k];
                send_bit(b);
                crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h8005 : 16'h0000);
            end
        end
        for (int k = 15; k >= 0; k--) send_bit(~crc[k] ^ (corrupt && k == 3));
        send_eop();
    endtask

    task automatic snap();
        @(negedge clk);
        r0 = n_ready;
        f0 = n_flush;
        s0 = store_q.size();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        dp_in = 1'b1;
        dm_in = 1'b0;
        buffer_occupancy = 7'd0;
        repeat (4) @(negedge clk);
        total++; if (rx_packet !== 3'd0) begin bad++; $display("FAIL reset_pid got=%0d want=0", rx_packet); end
        total++; if ({rx_error, rx_transfer_active, rx_data_ready, flush, rx_store_packet_data} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {rx_error, rx_transfer_active, rx_data_ready, flush, rx_store_packet_data});
        end
        total++; if ({rx_token_addr, rx_token_endp, rx_packet_data} !== 19'd0) begin
            bad++; $display("FAIL reset_fields got=%h want=0", {rx_token_addr, rx_token_endp, rx_packet_data});
        end
        n_rst = 1'b1;
        idle(10);
        @(negedge clk);
        total++; if ({rx_error, rx_transfer_active, rx_data_ready} !== 3'b0) begin
            bad++; $display("FAIL idle_flags got=%b want=000", {rx_error, rx_transfer_active, rx_data_ready});
        end
    endtask

    task automatic test_ack();
        snap();
        idle(4);
        send_sync();
        send_byte(8'hD2);
        send_eop();
        @(negedge clk);
        total++; if (rx_packet !== 3'd5) begin bad++; $display("FAIL ack_pid got=%0d want=5", rx_packet); end
        total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL ack_ready got=%0d want=1", n_ready - r0); end
        total++; if (store_q.size() - s0 !== 0) begin bad++; $display("FAIL ack_stores got=%0d want=0", store_q.size() - s0); end
        total++; if (n_flush - f0 !== 0) begin bad++; $display("FAIL ack_flush got=%0d want=0", n_flush - f0); end
        total++; if ({rx_error, rx_transfer_active} !== 2'b00) begin bad++; $display("FAIL ack_err_active got=%b want=00", {rx_error, rx_transfer_active}); end
    endtask

    task automatic test_data1();
        logic [7:0] exp_b[3];
        exp_b = '{8'h01, 8'h02, 8'h03};
        snap();
        idle(4);
        pl = '{8'h01, 8'h02, 8'h03};
        send_data(8'h4B, 1'b0);
        @(negedge clk);
        total++; if (n_flush - f0 !== 1) begin bad++; $display("FAIL d1_flush got=%0d want=1", n_flush - f0); end
        total++; if (store_q.size() - s0 !== 3) begin bad++; $display("FAIL d1_stores got=%0d want=3", store_q.size() - s0); end
        for (int i = 0; i < 3; i++) begin
            if (s0 + i < store_q.size()) begin
                total++; if (store_q[s0 + i] !== exp_b[i]) begin bad++; $display("FAIL d1_byte%0d got=%h want=%h", i, store_q[s0 + i], exp_b[i]); end
            end
        end
        total++; if (rx_packet !== 3'd4) begin bad++; $display("FAIL d1_pid got=%0d want=4", rx_packet); end
        total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL d1_ready got=%0d want=1", n_ready - r0); end
        total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL d1_err got=%b want=0", rx_error); end
    endtask

    task automatic test_token();
        logic [10:0] f;
        logic [4:0]  crc;
        snap();
        idle(4);
        send_sync();
        send_byte(8'h69);
        f = {4'd3, 7'h15};
        crc = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i]);
            crc = {crc[3:0], 1'b0} ^ ((crc[4] ^ f[i]) ? 5'h05 : 5'h00);
        end
        for (int k = 4; k >= 0; k--) send_bit(~crc[k]);
        send_eop();
        @(negedge clk);
        total++; if (rx_packet !== 3'd2) begin bad++; $display("FAIL tok_pid got=%0d want=2", rx_packet); end
        total++; if (rx_token_addr !== 7'h15) begin bad++; $display("FAIL tok_addr got=%h want=15", rx_token_addr); end
        total++; if (rx_token_endp !== 4'd3) begin bad++; $display("FAIL tok_endp got=%0d want=3", rx_token_endp); end
        total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL tok_ready got=%0d want=1", n_ready - r0); end
    endtask

    task automatic test_stuffing();
        snap();
        idle(4);
        pl = '{8'hFF, 8'hFF, 8'hFF};
        send_data(8'hC3, 1'b0);
        @(negedge clk);
        total++; if (store_q.size() - s0 !== 3) begin bad++; $display("FAIL stuff_stores got=%0d want=3", store_q.size() - s0); end
        for (int i = 0; i < 3; i++) begin
            if (s0 + i < store_q.size()) begin
                total++; if (store_q[s0 + i] !== 8'hFF) begin bad++; $display("FAIL stuff_byte%0d got=%h want=ff", i, store_q[s0 + i]); end
            end
        end
        total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL stuff_ready got=%0d want=1", n_ready - r0); end
        snap();
        idle(4);
        send_sync();
        send_byte(8'hC3);
        bad_stuff = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        bad_stuff = 1'b0;
        send_eop();
        @(negedge clk);
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL badstuff_err got=%b want=1", rx_error); end
        total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL badstuff_ready got=%0d want=0", n_ready - r0); end
    endtask

    task automatic test_bad_pid();
        snap();
        idle(4);
        send_sync();
        send_byte(8'h0F);
        idle(12);
        @(negedge clk);
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL badpid_err got=%b want=1", rx_error); end
        total++; if (rx_transfer_active !== 1'b0) begin bad++; $display("FAIL badpid_active got=%b want=0", rx_transfer_active); end
        total++; if (store_q.size() - s0 !== 0) begin bad++; $display("FAIL badpid_stores got=%0d want=0", store_q.size() - s0); end
        total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL badpid_ready got=%0d want=0", n_ready - r0); end
        snap();
        pl = '{8'hAA};
        send_data(8'hC3, 1'b0);
        @(negedge clk);
        total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL recover_err got=%b want=0", rx_error); end
        total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL recover_ready got=%0d want=1", n_ready - r0); end
        total++; if (rx_packet !== 3'd3) begin bad++; $display("FAIL recover_pid got=%0d want=3", rx_packet); end
        total++; if (store_q.size() - s0 !== 1) begin bad++; $display("FAIL recover_stores got=%0d want=1", store_q.size() - s0); end
        else begin
            total++; if (store_q[s0] !== 8'hAA) begin bad++; $display("FAIL recover_byte got=%h want=aa", store_q[s0]); end
        end
    endtask

    task automatic test_crc_err();
        snap();
        idle(4);
        pl = '{8'h11, 8'h22};
        send_data(8'h4B, 1'b1);
        @(negedge clk);
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL crc_err got=%b want=1", rx_error); end
        total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL crc_ready got=%0d want=0", n_ready - r0); end
    endtask

    task automatic test_full();
        snap();
        idle(4);
        buffer_occupancy = 7'd64;
        pl = '{8'h01, 8'h02, 8'h03};
        send_data(8'hC3, 1'b0);
        @(negedge clk);
        buffer_occupancy = 7'd0;
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL full_err got=%b want=1", rx_error); end
        total++; if (store_q.size() - s0 !== 0) begin bad++; $display("FAIL full_stores got=%0d want=0", store_q.size() - s0); end
        total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL full_ready got=%0d want=0", n_ready - r0); end
    endtask

    task automatic test_oversize();
        snap();
        idle(4);
        pl.delete();
        for (int i = 0; i < 65; i++) pl.push_back(8'(i));
        send_data(8'h4B, 1'b0);
        @(negedge clk);
        total++; if (rx_error !== 1'b1) begin bad++; $display("FAIL over_err got=%b want=1", rx_error); end
        total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL over_ready got=%0d want=0", n_ready - r0); end
        total++; if (store_q.size() - s0 !== 64) begin bad++; $display("FAIL over_stores got=%0d want=64", store_q.size() - s0); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data1();
        test_token();
        test_stuffing();
        test_bad_pid();
        test_crc_err();
        test_full();
        test_oversize();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
